// File: rtl/hvsync_decoder_if.sv
// rtl/hvsync_decoder_if.sv - video stream and decoded-timing bundle for hvsync_decoder

interface hvsync_decoder_if;
  logic        hsync;
  logic        vsync;
  logic [2:0]  rgb;
  logic [15:0] hpos;
  logic [15:0] vpos;
  logic [15:0] line_len;
  logic [15:0] frame_lines;
  logic        locked;
  logic        frame_start;
  logic [23:0] lit_count;

  // Video source side: drives the raw stream, observes the decoded timing
  modport master (
    output hsync, vsync, rgb,
    input  hpos, vpos, line_len, frame_lines, locked, frame_start, lit_count
  );

  // Decoder side
  modport slave (
    input  hsync, vsync, rgb,
    output hpos, vpos, line_len, frame_lines, locked, frame_start, lit_count
  );
endinterface

// File: rtl/hvsync_decoder.sv
// rtl/hvsync_decoder.sv - recovers hpos/vpos, line/frame geometry, lock and lit-pixel count from hsync/vsync/rgb

module hvsync_decoder #(
  parameter bit          SYNC_POL    = 1'b1,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic            clk,
  input  logic            reset,
  hvsync_decoder_if.slave vid
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  // Input stage
  logic       hs_s_q, hs_d_q, vs_s_q, vs_d_q;
  logic [2:0] rgb_s_q;

  // Counters and measured geometry
  logic [15:0] hcount_q, hcount_d;
  logic [15:0] vcount_q, vcount_d;
  logic [15:0] line_len_q, line_len_d;
  logic [15:0] frame_lines_q, frame_lines_d;
  logic [23:0] acc_q, acc_d;
  logic [23:0] lit_count_q, lit_count_d;

  // Lock tracking
  state_t      state_q, state_d;
  logic [15:0] ref_len_q, ref_len_d;
  logic [15:0] ref_lines_q, ref_lines_d;
  logic [3:0]  match_cnt_q, match_cnt_d;
  logic [3:0]  match_nxt;
  logic        locked_q, locked_d;
  logic        frame_start_q, frame_start_d;

  logic        hs_edge, vs_edge, rgb_lit;
  logic        h_sat, v_sat;
  logic [15:0] hcount_inc, vcount_inc;
  logic [23:0] acc_inc;

  assign hs_edge = hs_s_q & ~hs_d_q;
  assign vs_edge = vs_s_q & ~vs_d_q;
  assign rgb_lit = |rgb_s_q;
  assign h_sat   = &hcount_q;
  assign v_sat   = &vcount_q;

  // hcount_inc doubles as the saturated "hcount + 1" used for line length
  assign hcount_inc = h_sat ? hcount_q : hcount_q + 16'd1;
  assign vcount_inc = v_sat ? vcount_q : vcount_q + 16'd1;
  assign acc_inc    = (&acc_q) ? acc_q : acc_q + {23'd0, rgb_lit};
  assign match_nxt  = match_cnt_q + 4'd1;

  // Sync polarity normalisation and edge-detect delay line
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_s_q  <= 1'b0;
      hs_d_q  <= 1'b0;
      vs_s_q  <= 1'b0;
      vs_d_q  <= 1'b0;
      rgb_s_q <= 3'd0;
    end else begin
      hs_s_q  <= (vid.hsync == SYNC_POL);
      vs_s_q  <= (vid.vsync == SYNC_POL);
      rgb_s_q <= vid.rgb;
      hs_d_q  <= hs_s_q;
      vs_d_q  <= vs_s_q;
    end
  end

  // Counter next state; a vsync edge outranks a coincident hsync edge on vcount
  always_comb begin
    hcount_d      = hcount_inc;
    line_len_d    = line_len_q;
    vcount_d      = vcount_q;
    frame_lines_d = frame_lines_q;
    acc_d         = acc_inc;
    lit_count_d   = lit_count_q;
    if (hs_edge) begin
      line_len_d = hcount_inc;
      hcount_d   = 16'd0;
    end
    if (vs_edge) begin
      frame_lines_d = vcount_q;
      vcount_d      = 16'd0;
    end else if (hs_edge) begin
      vcount_d = vcount_inc;
    end
    if (vs_edge) begin
      lit_count_d = acc_q;
      acc_d       = {23'd0, rgb_lit};
    end
  end

  // Lock FSM next state; counter saturation forces a fresh search
  always_comb begin
    state_d     = state_q;
    ref_len_d   = ref_len_q;
    ref_lines_d = ref_lines_q;
    match_cnt_d = match_cnt_q;
    case (state_q)
      SEARCH: begin
        if (vs_edge) begin
          ref_len_d   = line_len_q;
          ref_lines_d = vcount_q;
          match_cnt_d = 4'd0;
          state_d     = VERIFY;
        end
      end
      VERIFY: begin
        if (vs_edge) begin
          if ((line_len_q == ref_len_q) && (vcount_q == ref_lines_q)) begin
            match_cnt_d = match_nxt;
            if (match_nxt == LOCK_N) begin
              state_d = LOCKED;
            end
          end else begin
            ref_len_d   = line_len_q;
            ref_lines_d = vcount_q;
            match_cnt_d = 4'd0;
          end
        end
      end
      LOCKED: begin
        if ((vs_edge && (vcount_q != ref_lines_q)) ||
            (hs_edge && (hcount_inc != ref_len_q))) begin
          state_d     = SEARCH;
          match_cnt_d = 4'd0;
        end
      end
      default: begin
        state_d     = SEARCH;
        match_cnt_d = 4'd0;
      end
    endcase
    if (h_sat || v_sat) begin
      state_d     = SEARCH;
      match_cnt_d = 4'd0;
    end
  end

  assign locked_d      = (state_d == LOCKED);
  assign frame_start_d = vs_edge && (state_d == LOCKED);

  // Counter, measurement and lock state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      hcount_q      <= 16'd0;
      vcount_q      <= 16'd0;
      line_len_q    <= 16'd0;
      frame_lines_q <= 16'd0;
      acc_q         <= 24'd0;
      lit_count_q   <= 24'd0;
      state_q       <= SEARCH;
      ref_len_q     <= 16'd0;
      ref_lines_q   <= 16'd0;
      match_cnt_q   <= 4'd0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      acc_q         <= acc_d;
      lit_count_q   <= lit_count_d;
      state_q       <= state_d;
      ref_len_q     <= ref_len_d;
      ref_lines_q   <= ref_lines_d;
      match_cnt_q   <= match_cnt_d;
      locked_q      <= locked_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vid.hpos        = hcount_q;
  assign vid.vpos        = vcount_q;
  assign vid.line_len    = line_len_q;
  assign vid.frame_lines = frame_lines_q;
  assign vid.locked      = locked_q;
  assign vid.frame_start = frame_start_q;
  assign vid.lit_count   = lit_count_q;

endmodule

// File: tb/tb_hvsync_decoder.sv
// tb/tb_hvsync_decoder.sv - directed bench for hvsync_decoder with a 20x10 source in both sync polarities

module tb_hvsync_decoder;

  logic clk = 1'b0;
  logic reset = 1'b1;

  hvsync_decoder_if vid_p ();
  hvsync_decoder_if vid_n ();

  hvsync_decoder #(.SYNC_POL(1'b1), .LOCK_FRAMES(2)) dut_p (
    .clk   (clk),
    .reset (reset),
    .vid   (vid_p)
  );

  hvsync_decoder #(.SYNC_POL(1'b0), .LOCK_FRAMES(2)) dut_n (
    .clk   (clk),
    .reset (reset),
    .vid   (vid_n)
  );

  always #5 clk = ~clk;

  // Source: 20 clocks/line, 10 lines/frame, hsync at h 14..16, vsync on lines 7..8,
  // rgb lit at (2,3..11) and at (7,0), i.e. 10 lit cycles per frame.
  int gen_h = 0;
  int gen_v = 0;
  int len_cur = 20;
  int last_h = 0;
  int last_v = 0;
  bit kill = 1'b0;

  int n_checks = 0;
  int n_err = 0;
  int pulses;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic hs, vs;
    logic [2:0] px;
    hs = (gen_h >= 14) && (gen_h < 17) && !kill;
    vs = (gen_v >= 7) && (gen_v < 9);
    px = (((gen_v == 2) && (gen_h >= 3) && (gen_h < 12)) || ((gen_v == 7) && (gen_h == 0))) ? 3'b101 : 3'b000;
    vid_p.hsync = hs;
    vid_p.vsync = vs;
    vid_p.rgb   = px;
    vid_n.hsync = ~hs;
    vid_n.vsync = ~vs;
    vid_n.rgb   = px;
    last_h = gen_h;
    last_v = gen_v;
    @(posedge clk);
    #1;
    gen_h++;
    if (gen_h >= len_cur) begin
      gen_h = 0;
      len_cur = 20;
      gen_v = (gen_v == 9) ? 0 : gen_v + 1;
    end
  endtask

  // Tick until the last emitted source position is (v,h); v < 0 matches any line
  task automatic run_to(input int v, input int h);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(((v < 0) || (last_v == v)) && (last_h == h)) && (n < 70000));
  endtask

  initial begin
    tick();
    tick();
    check("rst_hpos", vid_p.hpos, 0);
    check("rst_vpos", vid_p.vpos, 0);
    check("rst_line_len", vid_p.line_len, 0);
    check("rst_frame_lines", vid_p.frame_lines, 0);
    check("rst_lit", vid_p.lit_count, 0);
    check("rst_locked", vid_p.locked, 0);
    check("rst_fs", vid_p.frame_start, 0);
    check("rst_n_locked", vid_n.locked, 0);
    reset = 1'b0;

    run_to(0, 15);
    check("first_line_len", vid_p.line_len, 14);
    check("n_first_line_len", vid_n.line_len, 14);
    run_to(1, 14);
    check("hpos_before_wrap0", vid_p.hpos, 19);
    check("vpos_line1", vid_p.vpos, 1);
    run_to(1, 15);
    check("line_len_full", vid_p.line_len, 20);
    check("n_line_len_full", vid_n.line_len, 20);
    check("hpos_wrap0", vid_p.hpos, 0);
    check("vpos_step0", vid_p.vpos, 2);
    check("lit_before_vs", vid_p.lit_count, 0);

    run_to(7, 0);
    check("vpos_partial", vid_p.vpos, 7);
    tick();
    check("frame_lines_partial", vid_p.frame_lines, 7);
    check("vpos_clear", vid_p.vpos, 0);
    check("lit_partial", vid_p.lit_count, 9);
    check("locked_vs1", vid_p.locked, 0);

    run_to(7, 1);
    check("frame_lines_full", vid_p.frame_lines, 10);
    check("n_frame_lines_full", vid_n.frame_lines, 10);
    check("lit_full", vid_p.lit_count, 10);
    check("locked_vs2", vid_p.locked, 0);
    run_to(7, 1);
    check("locked_vs3", vid_p.locked, 0);
    check("n_locked_vs3", vid_n.locked, 0);
    run_to(7, 0);
    check("locked_pre_vs4", vid_p.locked, 0);
    tick();
    check("locked_vs4", vid_p.locked, 1);
    check("n_locked_vs4", vid_n.locked, 1);
    check("fs_enter_lock", vid_p.frame_start, 1);
    check("n_fs_enter_lock", vid_n.frame_start, 1);
    tick();
    check("fs_one_cycle", vid_p.frame_start, 0);

    pulses = 0;
    for (int i = 0; i < 199; i++) begin
      tick();
      if (vid_p.frame_start === 1'b1) pulses++;
    end
    check("fs_pulses_per_frame", pulses, 1);
    check("fs_period", vid_p.frame_start, 1);
    check("lit_locked", vid_p.lit_count, 10);

    run_to(4, 14);
    check("hpos_before_wrap", vid_p.hpos, 19);
    check("vpos_before_wrap", vid_p.vpos, 7);
    tick();
    check("hpos_wrap", vid_p.hpos, 0);
    check("vpos_step", vid_p.vpos, 8);

    run_to(2, 0);
    len_cur = 21;
    run_to(3, 14);
    check("locked_before_stretch", vid_p.locked, 1);
    tick();
    check("unlock_stretch", vid_p.locked, 0);
    check("n_unlock_stretch", vid_n.locked, 0);
    check("line_len_stretch", vid_p.line_len, 21);
    run_to(7, 1);
    check("relock_vs1", vid_p.locked, 0);
    check("frame_lines_stretch", vid_p.frame_lines, 10);
    run_to(7, 1);
    check("relock_vs2", vid_p.locked, 0);
    run_to(7, 1);
    check("relock_vs3", vid_p.locked, 1);
    check("n_relock_vs3", vid_n.locked, 1);
    check("relock_fs", vid_p.frame_start, 1);

    run_to(3, 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_hpos", vid_p.hpos, 0);
    check("mid_rst_vpos", vid_p.vpos, 0);
    check("mid_rst_line_len", vid_p.line_len, 0);
    check("mid_rst_frame_lines", vid_p.frame_lines, 0);
    check("mid_rst_lit", vid_p.lit_count, 0);
    check("mid_rst_locked", vid_p.locked, 0);
    check("mid_rst_fs", vid_p.frame_start, 0);
    run_to(7, 1);
    check("post_rst_frame_lines", vid_p.frame_lines, 4);
    check("post_rst_lit", vid_p.lit_count, 0);
    check("post_rst_vs1", vid_p.locked, 0);
    run_to(7, 1);
    check("post_rst_vs2", vid_p.locked, 0);
    check("post_rst_lit2", vid_p.lit_count, 10);
    run_to(7, 1);
    check("post_rst_vs3", vid_p.locked, 0);
    run_to(7, 1);
    check("post_rst_vs4", vid_p.locked, 1);
    check("n_post_rst_vs4", vid_n.locked, 1);

    run_to(9, 19);
    kill = 1'b1;
    for (int i = 0; i < 65600; i++) begin
      tick();
    end
    check("sat_hpos", vid_p.hpos, 16'hFFFF);
    check("n_sat_hpos", vid_n.hpos, 16'hFFFF);
    check("sat_locked", vid_p.locked, 0);
    check("n_sat_locked", vid_n.locked, 0);
    check("sat_line_len_held", vid_p.line_len, 20);
    run_to(-1, 19);
    kill = 1'b0;
    run_to(-1, 15);
    check("resume_line_len_sat", vid_p.line_len, 16'hFFFF);
    check("n_resume_line_len_sat", vid_n.line_len, 16'hFFFF);
    check("resume_hpos", vid_p.hpos, 0);
    run_to(-1, 15);
    check("resume_line_len", vid_p.line_len, 20);
    check("n_resume_line_len", vid_n.line_len, 20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
